// File: rtl/tick_pkg.sv
// Shared types and helpers for the tick_countdown timer: FSM states, 7-segment
// constants and the load clamp.
package tick_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } tick_state_t;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_ZERO  = 8'h3F;

   // Zero or an over-range request both fall back to the full-length run.
   function automatic logic [31:0] clamp_units(input logic [31:0] val,
                                               input logic [31:0] max_units);
      if (val == 32'd0 || val > max_units) begin
         return max_units;
      end
      return val;
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational unit-count to 7-segment map, {dp,g,f,e,d,c,b,a} active-high.
// Values above 9 blank the digit.
module seg7_encode
   import tick_pkg::*;
#(
   parameter int UNITS_W = 4
) (
   input  logic [UNITS_W-1:0] i_units,
   output logic [7:0]         o_seg
);

   logic [31:0] w_val;

   assign w_val = 32'(i_units);

   always_comb begin
      o_seg = SEG_BLANK;
      case (w_val)
         32'd0:   o_seg = SEG_ZERO;
         32'd1:   o_seg = 8'h06;
         32'd2:   o_seg = 8'h5B;
         32'd3:   o_seg = 8'h4F;
         32'd4:   o_seg = 8'h66;
         32'd5:   o_seg = 8'h6D;
         32'd6:   o_seg = 8'h7D;
         32'd7:   o_seg = 8'h07;
         32'd8:   o_seg = 8'h7F;
         32'd9:   o_seg = 8'h6F;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/tick_countdown.sv
// Countdown timer: loads a clamped unit count, decrements one unit every
// CLK_PER_UNIT clocks, supports pause and a scored stop press.
// Optional macro TICK_AUTO_RELOAD_EN: expiry reloads and keeps running.
module tick_countdown
   import tick_pkg::*;
#(
   parameter int CLK_PER_UNIT = 500,
   parameter int UNITS_W      = 4,
   parameter int MAX_UNITS    = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               start,
   input  logic               stop,
   input  logic               pause,
   input  logic [UNITS_W-1:0] load_units,
   input  logic [UNITS_W-1:0] goal,
   output logic [UNITS_W-1:0] units,
   output logic [7:0]         seg,
   output logic               busy,
   output logic               done,
   output logic               hit,
   output logic               timeout
);

   localparam int SUB_W = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
   localparam logic [SUB_W-1:0]   SUB_RELOAD = SUB_W'(CLK_PER_UNIT - 1);
   localparam logic [SUB_W-1:0]   SUB_ONE    = SUB_W'(1);
   localparam logic [UNITS_W-1:0] UNIT_ONE   = UNITS_W'(1);

   tick_state_t         r_state;
   logic [UNITS_W-1:0]  r_units;
   logic [SUB_W-1:0]    r_sub;
   logic                r_done;
   logic                r_hit;
   logic                r_timeout;

   tick_state_t         w_state_nxt;
   logic [UNITS_W-1:0]  w_units_nxt;
   logic [SUB_W-1:0]    w_sub_nxt;
   logic                w_done_nxt;
   logic                w_hit_nxt;
   logic                w_timeout_nxt;
   logic [UNITS_W-1:0]  w_load;
   logic                w_expire;
   logic [7:0]          w_seg;

   assign w_load = UNITS_W'(clamp_units(32'(load_units), 32'(MAX_UNITS)));

   // The last sub-tick of the last unit ends the run, so units never wraps.
   assign w_expire = (r_state == RUN) && (r_sub == '0) && (r_units <= UNIT_ONE);

   always_comb begin
      w_state_nxt   = r_state;
      w_units_nxt   = r_units;
      w_sub_nxt     = r_sub;
      w_done_nxt    = 1'b0;
      w_hit_nxt     = r_hit;
      w_timeout_nxt = r_timeout;

      if (!enable) begin
         w_state_nxt   = IDLE;
         w_hit_nxt     = 1'b0;
         w_timeout_nxt = 1'b0;
      end else begin
`ifdef TICK_AUTO_RELOAD_EN
         w_timeout_nxt = 1'b0;
`endif
         if (start) begin
            w_state_nxt   = RUN;
            w_units_nxt   = w_load;
            w_sub_nxt     = SUB_RELOAD;
            w_hit_nxt     = 1'b0;
            w_timeout_nxt = 1'b0;
         end else if (stop && (r_state != IDLE)) begin
            w_state_nxt   = IDLE;
            w_done_nxt    = 1'b1;
            w_hit_nxt     = (r_units == goal);
            w_timeout_nxt = 1'b0;
         end else begin
            case (r_state)
               RUN: begin
                  if (r_sub != '0) begin
                     w_sub_nxt = r_sub - SUB_ONE;
                  end else begin
                     w_sub_nxt   = SUB_RELOAD;
                     w_units_nxt = r_units - UNIT_ONE;
                  end
                  if (w_expire) begin
                     w_done_nxt    = 1'b1;
                     w_hit_nxt     = 1'b0;
                     w_timeout_nxt = 1'b1;
`ifdef TICK_AUTO_RELOAD_EN
                     w_units_nxt   = w_load;
                     w_state_nxt   = RUN;
`else
                     w_units_nxt   = '0;
                     w_state_nxt   = IDLE;
`endif
                  end else if (pause) begin
                     w_state_nxt = PAUSED;
                  end
               end
               PAUSED: begin
                  if (!pause) begin
                     w_state_nxt = RUN;
                  end
               end
               default: begin
                  w_state_nxt = r_state;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_units   <= '0;
         r_sub     <= '0;
         r_done    <= 1'b0;
         r_hit     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_units   <= w_units_nxt;
         r_sub     <= w_sub_nxt;
         r_done    <= w_done_nxt;
         r_hit     <= w_hit_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   seg7_encode #(
      .UNITS_W (UNITS_W)
   ) u_seg7 (
      .i_units (r_units),
      .o_seg   (w_seg)
   );

   assign units   = r_units;
   assign seg     = w_seg;
   assign busy    = (r_state != IDLE);
   assign done    = r_done;
   assign hit     = r_hit;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_tick_countdown.sv
// Randomized scoreboard bench for tick_countdown; the reference model tracks a
// single remaining-clock count per run and derives the displayed units from it.
module tb_tick_countdown;

   localparam int C    = 4;
   localparam int UW   = 4;
   localparam int MAXU = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          pause = 1'b0;
   logic [UW-1:0] load_units = '0;
   logic [UW-1:0] goal = '0;
   logic [UW-1:0] units;
   logic [7:0]    seg;
   logic          busy;
   logic          done;
   logic          hit;
   logic          timeout;

   tick_countdown #(
      .CLK_PER_UNIT (C),
      .UNITS_W      (UW),
      .MAX_UNITS    (MAXU)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .load_units (load_units),
      .goal       (goal),
      .units      (units),
      .seg        (seg),
      .busy       (busy),
      .done       (done),
      .hit        (hit),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int hit;
      int to;
      int units;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   int   m_rem = 0;
   bit   m_active = 1'b0;
   bit   m_paused = 1'b0;
   bit   m_hit = 1'b0;
   bit   m_to = 1'b0;

   logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   function automatic int clampf(int v);
      return (v == 0 || v > MAXU) ? MAXU : v;
   endfunction

   function automatic int units_of(int rem);
      return (rem + C - 1) / C;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference model: one remaining-clock count per run.
   always @(posedge clk or posedge rst) begin
      exp_t e;
      if (rst) begin
         m_rem = 0;
         m_active = 1'b0;
         m_paused = 1'b0;
         m_hit = 1'b0;
         m_to = 1'b0;
         exp_q.delete();
      end else if (!enable) begin
         m_active = 1'b0;
         m_paused = 1'b0;
         m_hit = 1'b0;
         m_to = 1'b0;
      end else begin
`ifdef TICK_AUTO_RELOAD_EN
         m_to = 1'b0;
`endif
         if (start) begin
            m_rem = clampf(int'(load_units)) * C;
            m_active = 1'b1;
            m_paused = 1'b0;
            m_hit = 1'b0;
            m_to = 1'b0;
         end else if (stop && m_active) begin
            m_hit = (units_of(m_rem) == int'(goal));
            m_to = 1'b0;
            m_active = 1'b0;
            m_paused = 1'b0;
            e.hit = int'(m_hit);
            e.to = 0;
            e.units = units_of(m_rem);
            exp_q.push_back(e);
         end else if (m_active && !m_paused) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_hit = 1'b0;
               m_to = 1'b1;
`ifdef TICK_AUTO_RELOAD_EN
               m_rem = clampf(int'(load_units)) * C;
`else
               m_active = 1'b0;
`endif
               e.hit = 0;
               e.to = 1;
               e.units = units_of(m_rem);
               exp_q.push_back(e);
            end else if (pause) begin
               m_paused = 1'b1;
            end
         end else if (m_active && m_paused && !pause) begin
            m_paused = 1'b0;
         end
      end
   end

   // Monitor: per-cycle state checks plus scoreboard pop on every done.
   always @(negedge clk) begin
      int   eu;
      exp_t e;
      eu = units_of(m_rem);
      chk("units", 32'(units), eu);
      chk("busy", 32'(busy), 32'(m_active));
      chk("seg", 32'(seg), (eu <= 9) ? 32'(seg_tab[eu]) : 32'd0);
      chk("hit_level", 32'(hit), 32'(m_hit));
      chk("timeout_level", 32'(timeout), 32'(m_to));
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_spurious: got done=1 expected done=0 at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("done_hit", 32'(hit), e.hit);
            chk("done_timeout", 32'(timeout), e.to);
            chk("done_units", 32'(units), e.units);
         end
      end else if (exp_q.size() != 0) begin
         void'(exp_q.pop_front());
         vectors++;
         miscompares++;
         $display("FAIL done_missing: got done=%b expected done=1 at %0t", done, $time);
      end else begin
         chk("done_idle", 32'(done), 32'd0);
      end
   end

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(int ld);
      load_units = UW'(ld);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   initial begin
      idle(2);
      rst = 1'b0;
      enable = 1'b1;
      idle(2);

      do_start(3); idle(16);
      do_start(0); idle(22);
      do_start(9); idle(22);

      goal = UW'(2); do_start(3); idle(5); do_stop(); idle(3);
      goal = UW'(3); do_start(3); idle(5); do_stop(); idle(3);

      do_start(3); idle(3); pause = 1'b1; idle(10); pause = 1'b0; idle(20);
      goal = UW'(3); do_start(3); idle(2); pause = 1'b1; idle(6); do_stop(); pause = 1'b0; idle(3);

      goal = UW'(1); do_start(1); idle(3); do_stop(); idle(3);

      do_start(4); idle(5);
      load_units = UW'(2); start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      idle(10);

      do_start(5); idle(6); enable = 1'b0; idle(3);
      do_start(2); idle(2); enable = 1'b1; idle(3);

      do_start(1); idle(3); pause = 1'b1; idle(1); pause = 1'b0; idle(3);

      do_start(3); idle(30); do_stop(); idle(2);

      do_start(3); idle(5);
      #3 rst = 1'b1;
      #1;
      chk("rst_units", 32'(units), 32'd0);
      chk("rst_seg", 32'(seg), 32'h3F);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 99) != 0);
         start = ($urandom_range(0, 59) == 0);
         stop = ($urandom_range(0, 44) == 0);
         if ($urandom_range(0, 14) == 0) pause = ~pause;
         load_units = UW'($urandom_range(0, 15));
         goal = UW'($urandom_range(0, 5));
         @(negedge clk);
      end
      start = 1'b0;
      stop = 1'b0;
      pause = 1'b0;
      enable = 1'b1;
      idle(3);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tick_countdown.md
Name: tick_countdown

Overview:
- Parametrised countdown timer for the TickGame datapath, the next generation of the fixed 5-unit game counter.
- Loads a unit count, counts it down at CLK_PER_UNIT clocks per unit, and drives a 7-segment digit with the remaining units.
- The player's stop press freezes the count and is scored against a goal; otherwise the timer expires on its own.
- Adds pause/resume, a stop/score path, load clamping and one-cycle result pulses.

Parameters:
- CLK_PER_UNIT, 500, clk cycles per displayed unit (>=2)
- UNITS_W, 4, width of unit count, load and goal fields
- MAX_UNITS, 5, load clamp value (1..9)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  block enable; low forces IDLE
- start  in  1  one-cycle pulse; loads and starts a run
- stop  in  1  one-cycle pulse; player stop press
- pause  in  1  level; holds the count while high
- load_units  in  UNITS_W  units to load on start
- goal  in  UNITS_W  target remaining-unit value for scoring
- units  out  UNITS_W  remaining whole units
- seg  out  8  7-segment pattern of units, {dp,g,f,e,d,c,b,a}, active-high
- busy  out  1  high in RUN or PAUSED
- done  out  1  one-cycle pulse when a run ends, by stop or by expiry
- hit  out  1  valid with done: stop occurred with units==goal
- timeout  out  1  valid with done: run ended by expiry

Behaviour:
- Reset (async, rst=1) sets:
  - state=IDLE, units=0, sub=0, done=0, hit=0, timeout=0, busy=0.
  - seg=8'h3F, showing digit 0.
- States:
  - IDLE -> RUN on start.
  - RUN -> PAUSED on pause=1.
  - PAUSED -> RUN on pause=0.
  - RUN or PAUSED -> IDLE on stop.
  - RUN -> IDLE on expiry.
- All transitions are synchronous and require enable=1.
- enable=0, any state:
  - Next state is IDLE; done, hit and timeout are cleared.
  - units and sub hold, so the display keeps the last value.
  - start, stop and pause are ignored.
- Start (enable=1, any state):
  - units <= clamp(load_units); clamp maps 0 or values >MAX_UNITS to MAX_UNITS.
  - sub <= CLK_PER_UNIT-1; done, hit and timeout are cleared; state=RUN.
- RUN, each clk:
  - If sub!=0: sub decrements.
  - If sub==0: sub reloads to CLK_PER_UNIT-1 and units decrements.
  - If sub==0 and units==1: units becomes 0 and the run expires.
  - Expiry occurs exactly N*CLK_PER_UNIT clocks after the start edge, where N is the clamped load.
- Expiry, registered:
  - done=1 for one cycle, timeout=1, hit=0, state=IDLE.
- Stop, in RUN or PAUSED:
  - Count freezes and state=IDLE.
  - done=1 for one cycle; hit=(units==goal) using the pre-edge units value; timeout=0.
- Stop in IDLE is ignored.
- PAUSED: units and sub hold; stop is accepted.
- Output holding after a run:
  - done is a single-cycle pulse.
  - hit and timeout hold their values until the next start, enable=0 or rst.
- Simultaneous events, priority start > stop > expiry > pause:
  - stop on the expiry cycle scores as a stop against the pre-edge units; timeout=0.
  - start together with stop restarts the run; no done pulse.
  - pause on the expiry cycle: expiry wins.
- seg is purely combinational from units:
  - Standard digit patterns 0-9.
  - Values >9 give 8'h00 (blank); unreachable with a legal MAX_UNITS.
- Reset asserted mid-run aborts immediately with no done pulse.
- Width rules:
  - sub width is clog2(CLK_PER_UNIT).
  - The units decrement never wraps, because the transition at units==1 forces the end of the run.

Optional Feature:
- Macro: TICK_AUTO_RELOAD_EN.
- Defined:
  - On expiry, done and timeout pulse as normal.
  - The block reloads units from clamp(load_units) and sub from CLK_PER_UNIT-1, and stays in RUN; busy stays high.
  - Only stop or enable=0 ends the run.
  - timeout is a one-cycle pulse, aligned with done.
- Undefined: expiry returns to IDLE as specified above.

Decomposition:
- Package tick_pkg holds:
  - the state enum (IDLE, RUN, PAUSED);
  - the SEG_BLANK and SEG_ZERO constants;
  - the clamp function.
- One sub-module: seg7_encode, a combinational units -> seg map reused by the display mux.

Test Plan:
- All scenarios use CLK_PER_UNIT=4 and MAX_UNITS=5.
- Reset: rst=1 mid-run -> units=0, seg=8'h3F, done=0, busy=0 immediately, without waiting for a clk edge.
- Basic run: start with load_units=3 -> units reads 3,2,1, each for 4 clocks -> done and timeout pulse at clock 12; units=0, hit=0.
- Clamp: load_units=0 -> units=5. load_units=9 -> units=5; expiry at clock 20.
- Stop and score:
  - goal=2, stop while units=2 -> done=1 for one cycle, hit=1, timeout=0, units frozen at 2.
  - goal=3, same stop -> hit=0.
- Pause: pause high for 10 clocks mid-run -> expiry delayed by exactly 10 clocks; stop during pause scores correctly.
- Priority and enable:
  - stop on the expiry cycle -> timeout=0 and hit scored against pre-edge units.
  - start with stop -> restart, no done pulse.
  - enable=0 mid-run -> IDLE, units held.
  - With TICK_AUTO_RELOAD_EN: two back-to-back done pulses 12 clocks apart for load 3.
